// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder.
//   - Opcode values recognised in the first byte of a frame.
//   - Decoder FSM state encoding.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h05;
    localparam logic [7:0] OP_ID     = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Command/register-access layer behind the SPI byte shifter.
// Decodes frames of {opcode, address (MSB first), data...} and drives a
// single-master register bus. Read data and status bytes go back to the
// shifter through tx_vld/tx_dat.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start, busy         frame start pulse / frame active (SSN low)
//   rx_vld, rx_dat      received byte strobe and value
//   tx_overrun          sticky overrun flag from the shifter (reported by STATUS)
//   tx_vld, tx_dat      byte to load into the shifter's pending buffer
//   bus_addr, bus_wdat  register bus address and write data
//   bus_we, bus_re      one-cycle write / read strobes
//   bus_rdat, bus_rvld  read response from the register bus
//   rd_late             sticky: next byte arrived before the read response
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int         ADDR_BYTES = 2,
    parameter int         ADDR_W     = 16,
    parameter logic [7:0] ID_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              busy,
    input  logic              rx_vld,
    input  logic [7:0]        rx_dat,
    input  logic              tx_overrun,
    output logic              tx_vld,
    output logic [7:0]        tx_dat,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdat,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdat,
    input  logic              bus_rvld,
    output logic              rd_late
);

    localparam logic [1:0] LAST_ADDR = 2'(ADDR_BYTES - 1);

    state_t              state_reg, state_next;
    logic [1:0]          cnt_reg, cnt_next;
    logic                is_read_reg, is_read_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                rd_pend_reg, rd_pend_next;
    logic                rd_late_reg, rd_late_next;
    logic                tx_vld_reg, tx_vld_next;
    logic [7:0]          tx_dat_reg, tx_dat_next;
    logic [ADDR_W-1:0]   bus_addr_reg, bus_addr_next;
    logic [7:0]          bus_wdat_reg, bus_wdat_next;
    logic                bus_we_reg, bus_we_next;
    logic                bus_re_reg, bus_re_next;

    // Shifting the new byte in at the bottom and truncating drops any
    // received address bits above ADDR_W.
    logic [ADDR_W+7:0]   addr_shift;
    logic [ADDR_W-1:0]   addr_inc;
    logic                rvld_take;

    assign addr_shift = {addr_reg, rx_dat};
    assign addr_inc   = addr_reg + 1'b1;
    // Only a response to a read we actually issued in this frame counts;
    // anything else (e.g. after an abort) is dropped.
    assign rvld_take  = (state_reg == RDATA) && rd_pend_reg && bus_rvld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            is_read_reg  <= 1'b0;
            addr_reg     <= '0;
            rd_pend_reg  <= 1'b0;
            rd_late_reg  <= 1'b0;
            tx_vld_reg   <= 1'b0;
            tx_dat_reg   <= '0;
            bus_addr_reg <= '0;
            bus_wdat_reg <= '0;
            bus_we_reg   <= 1'b0;
            bus_re_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            is_read_reg  <= is_read_next;
            addr_reg     <= addr_next;
            rd_pend_reg  <= rd_pend_next;
            rd_late_reg  <= rd_late_next;
            tx_vld_reg   <= tx_vld_next;
            tx_dat_reg   <= tx_dat_next;
            bus_addr_reg <= bus_addr_next;
            bus_wdat_reg <= bus_wdat_next;
            bus_we_reg   <= bus_we_next;
            bus_re_reg   <= bus_re_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        is_read_next  = is_read_reg;
        addr_next     = addr_reg;
        rd_pend_next  = rd_pend_reg;
        rd_late_next  = rd_late_reg;
        tx_vld_next   = 1'b0;
        tx_dat_next   = tx_dat_reg;
        bus_addr_next = bus_addr_reg;
        bus_wdat_next = bus_wdat_reg;
        bus_we_next   = 1'b0;
        bus_re_next   = 1'b0;

        if (!busy) begin
            // Frame ended: forget any read still in flight.
            state_next   = IDLE;
            cnt_next     = '0;
            rd_pend_next = 1'b0;
        end else if (start) begin
            state_next   = CMD;
            cnt_next     = '0;
            rd_pend_next = 1'b0;
        end else begin
            case (state_reg)
                CMD: begin
                    if (rx_vld) begin
                        case (rx_dat)
                            OP_WRITE: begin
                                is_read_next = 1'b0;
                                state_next   = ADDR;
                            end
                            OP_READ: begin
                                is_read_next = 1'b1;
                                state_next   = ADDR;
                            end
                            OP_STATUS: begin
                                tx_vld_next = 1'b1;
                                tx_dat_next = {6'b0, rd_late_reg, tx_overrun};
                                state_next  = IGNORE;
                            end
                            OP_ID: begin
                                tx_vld_next = 1'b1;
                                tx_dat_next = ID_BYTE;
                                state_next  = IGNORE;
                            end
                            default: state_next = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_vld) begin
                        addr_next = addr_shift[ADDR_W-1:0];
                        if (cnt_reg == LAST_ADDR) begin
                            cnt_next = '0;
                            if (is_read_reg) begin
                                // Prefetch so the data is ready for the dummy slot.
                                state_next    = RDATA;
                                bus_re_next   = 1'b1;
                                bus_addr_next = addr_shift[ADDR_W-1:0];
                                rd_pend_next  = 1'b1;
                            end else begin
                                state_next = WDATA;
                            end
                        end else begin
                            cnt_next = cnt_reg + 2'd1;
                        end
                    end
                end
                WDATA: begin
                    if (rx_vld) begin
                        bus_we_next   = 1'b1;
                        bus_wdat_next = rx_dat;
                        bus_addr_next = addr_reg;
                        addr_next     = addr_inc;
                    end
                end
                RDATA: begin
                    if (rvld_take) begin
                        tx_vld_next  = 1'b1;
                        tx_dat_next  = bus_rdat;
                        addr_next    = addr_inc;
                        rd_pend_next = 1'b0;
                    end
                    if (rx_vld) begin
                        // A response landing in the same cycle is not late.
                        if (rd_pend_reg && !rvld_take) begin
                            rd_late_next = 1'b1;
                        end
                        bus_re_next   = 1'b1;
                        bus_addr_next = rvld_take ? addr_inc : addr_reg;
                        rd_pend_next  = 1'b1;
                    end
                end
                default: ;  // IDLE and IGNORE discard received bytes
            endcase
        end
    end

    assign tx_vld   = tx_vld_reg;
    assign tx_dat   = tx_dat_reg;
    assign bus_addr = bus_addr_reg;
    assign bus_wdat = bus_wdat_reg;
    assign bus_we   = bus_we_reg;
    assign bus_re   = bus_re_reg;
    assign rd_late  = rd_late_reg;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: a table of single frames plus
// hand-written read, abort and late-response sequences.
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        rx_vld;
    logic [7:0]  rx_dat;
    logic        tx_overrun;
    logic        tx_vld;
    logic [7:0]  tx_dat;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdat;
    logic        bus_we;
    logic        bus_re;
    logic [7:0]  bus_rdat = 8'h00;
    logic        bus_rvld = 1'b0;
    logic        rd_late;

    spi_cmd_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .rx_vld     (rx_vld),
        .rx_dat     (rx_dat),
        .tx_overrun (tx_overrun),
        .tx_vld     (tx_vld),
        .tx_dat     (tx_dat),
        .bus_addr   (bus_addr),
        .bus_wdat   (bus_wdat),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_rdat   (bus_rdat),
        .bus_rvld   (bus_rvld),
        .rd_late    (rd_late)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  dat;
    } ev_t;

    localparam logic [1:0] EV_WE = 2'd1;
    localparam logic [1:0] EV_RE = 2'd2;
    localparam logic [1:0] EV_TX = 2'd3;

    typedef struct {
        string       name;
        int          n;
        logic [39:0] b;     // bytes, first byte in the top bits
        logic        ovr;
        int          ne;
        ev_t         e0;
        ev_t         e1;
    } vec_t;

    ev_t  ev_q[$];
    ev_t  exp_q[$];
    vec_t vecs[6];

    int cyc         = 0;
    int last_in_cyc = -100;
    int bad_lat     = 0;
    int overlap     = 0;
    int n_pass      = 0;
    int n_total     = 0;
    int rsp_delay   = 2;
    logic [15:0] rsp_addr;

    function automatic ev_t ev(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: logs every bus strobe and tx byte and checks that each
    // follows its cause (latest rx_vld or bus_rvld) by exactly one cycle.
    always @(negedge clk) begin
        if (bus_we && bus_re) overlap++;
        if (bus_we) begin
            ev_q.push_back(ev(EV_WE, bus_addr, bus_wdat));
            if (cyc - last_in_cyc != 1) bad_lat++;
            $display("[%0d] bus_we addr=%04h wdat=%02h", cyc, bus_addr, bus_wdat);
        end
        if (bus_re) begin
            ev_q.push_back(ev(EV_RE, bus_addr, 8'h00));
            if (cyc - last_in_cyc != 1) bad_lat++;
            $display("[%0d] bus_re addr=%04h", cyc, bus_addr);
        end
        if (tx_vld) begin
            ev_q.push_back(ev(EV_TX, 16'h0000, tx_dat));
            if (cyc - last_in_cyc != 1) bad_lat++;
            $display("[%0d] tx_vld dat=%02h", cyc, tx_dat);
        end
        if (rx_vld || bus_rvld) last_in_cyc = cyc;
    end

    // Register-bus responder: read data is the low address byte xor 4C.
    always begin
        @(negedge clk);
        if (bus_re) begin
            rsp_addr = bus_addr;
            repeat (rsp_delay) @(posedge clk);
            #1;
            bus_rdat = rsp_addr[7:0] ^ 8'h4C;
            bus_rvld = 1'b1;
            @(posedge clk);
            #1;
            bus_rvld = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_events(input string name);
        check({name, " count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < ev_q.size())
                check($sformatf("%s ev%0d", name, i), 32'(ev_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back(ev(k, a, d));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_begin();
        ev_q.delete();
        exp_q.delete();
        busy  = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_vld = 1'b1;
        rx_dat = b;
        tick(1);
        rx_vld = 1'b0;
        tick(gap);
    endtask

    task automatic frame_end();
        tick(2);
        busy = 1'b0;
        tick(3);
    endtask

    initial begin
        vecs[0] = '{name:"write",    n:5, b:40'h021234AABB, ovr:1'b0, ne:2,
                    e0:ev(EV_WE, 16'h1234, 8'hAA), e1:ev(EV_WE, 16'h1235, 8'hBB)};
        vecs[1] = '{name:"wrap",     n:5, b:40'h02FFFF1122, ovr:1'b0, ne:2,
                    e0:ev(EV_WE, 16'hFFFF, 8'h11), e1:ev(EV_WE, 16'h0000, 8'h22)};
        vecs[2] = '{name:"status",   n:1, b:40'h0500000000, ovr:1'b1, ne:1,
                    e0:ev(EV_TX, 16'h0000, 8'h01), e1:'0};
        vecs[3] = '{name:"status_x", n:3, b:40'h0500000000, ovr:1'b0, ne:1,
                    e0:ev(EV_TX, 16'h0000, 8'h00), e1:'0};
        vecs[4] = '{name:"id",       n:2, b:40'h9F00000000, ovr:1'b0, ne:1,
                    e0:ev(EV_TX, 16'h0000, 8'hA5), e1:'0};
        vecs[5] = '{name:"unknown",  n:3, b:40'h7E12340000, ovr:1'b0, ne:0,
                    e0:'0, e1:'0};

        rst = 1'b1; start = 1'b0; busy = 1'b0; rx_vld = 1'b0;
        rx_dat = 8'h00; tx_overrun = 1'b0;
        tick(3);
        check("rst tx_vld",   32'(tx_vld),   0);
        check("rst tx_dat",   32'(tx_dat),   0);
        check("rst bus_addr", 32'(bus_addr), 0);
        check("rst bus_wdat", 32'(bus_wdat), 0);
        check("rst strobes",  32'({bus_we, bus_re}), 0);
        check("rst rd_late",  32'(rd_late),  0);
        rst = 1'b0;
        tick(2);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            tx_overrun = vecs[i].ovr;
            frame_begin();
            for (int j = 0; j < vecs[i].n; j++) send(vecs[i].b[39-8*j -: 8], 2);
            frame_end();
            if (vecs[i].ne > 0) expect_ev(vecs[i].e0.kind, vecs[i].e0.addr, vecs[i].e0.dat);
            if (vecs[i].ne > 1) expect_ev(vecs[i].e1.kind, vecs[i].e1.addr, vecs[i].e1.dat);
            check_events(vecs[i].name);
        end
        tx_overrun = 1'b0;

        // Read with prefetch, then a dummy byte reads the next address
        rsp_delay = 2;
        frame_begin();
        send(8'h03, 3);
        send(8'h00, 3);
        send(8'h10, 8);
        send(8'hFF, 8);
        frame_end();
        expect_ev(EV_RE, 16'h0010, 8'h00);
        expect_ev(EV_TX, 16'h0000, 8'h5C);
        expect_ev(EV_RE, 16'h0011, 8'h00);
        expect_ev(EV_TX, 16'h0000, 8'h5D);
        check_events("read");
        check("read rd_late", 32'(rd_late), 0);

        // Abort mid-address, then a clean write frame
        frame_begin();
        send(8'h02, 2);
        send(8'h00, 2);
        busy = 1'b0;
        tick(3);
        frame_begin();
        send(8'h02, 2);
        send(8'h00, 2);
        send(8'h01, 2);
        send(8'h77, 2);
        frame_end();
        expect_ev(EV_WE, 16'h0001, 8'h77);
        check_events("abort_wr");

        // Abort with a read outstanding: late response must be dropped
        rsp_delay = 6;
        frame_begin();
        send(8'h03, 2);
        send(8'h00, 2);
        send(8'h20, 1);
        busy = 1'b0;
        tick(12);
        expect_ev(EV_RE, 16'h0020, 8'h00);
        check_events("abort_rd");
        check("abort_rd rd_late", 32'(rd_late), 0);

        // Response delayed past the next byte: rd_late sets and sticks
        rsp_delay = 8;
        frame_begin();
        send(8'h03, 2);
        send(8'h00, 2);
        send(8'h30, 2);
        send(8'h00, 12);
        frame_end();
        check("late rd_late", 32'(rd_late), 1);
        rsp_delay = 2;
        frame_begin();
        send(8'h05, 2);
        frame_end();
        expect_ev(EV_TX, 16'h0000, 8'h02);
        check_events("status_late");
        frame_begin();
        send(8'h7E, 2);
        send(8'h55, 2);
        frame_end();
        check_events("unknown_late");
        check("late sticky", 32'(rd_late), 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("late cleared", 32'(rd_late), 0);

        check("latency", bad_lat, 0);
        check("we_re overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
